// File: rtl/router_pkt_gen.sv
// Packet source for the router input port: header {len,addr}, len LFSR payload
// beats, then a parity beat. All outputs registered; beats hold while busy is high.
module router_pkt_gen #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 2,
  parameter int                NUM_DEST  = 3,
  parameter logic [DATA_W-1:0] LFSR_POLY = 8'hB8,
  parameter logic [DATA_W-1:0] LFSR_SEED = 8'hA5,
  parameter int                CNT_W     = 16
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [DATA_W-ADDR_W-1:0] cfg_len,
  input  logic                     cfg_err_inj,
  input  logic                     busy,
  output logic                     pkt_valid,
  output logic [DATA_W-1:0]        data_in,
  output logic                     gen_active,
  output logic                     done,
  output logic                     addr_invld,
  output logic [CNT_W-1:0]         pkt_cnt
);

  localparam int LEN_W = DATA_W - ADDR_W;
  localparam logic [ADDR_W:0] DEST_LIM = (ADDR_W+1)'(NUM_DEST);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_PARITY  = 2'd3
  } state_t;

  state_t              r_state, w_state_nx;
  logic [LEN_W-1:0]    r_len, w_len;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic                r_err, w_err;
  logic [DATA_W-1:0]   r_lfsr, w_lfsr;
  logic [DATA_W-1:0]   r_acc, w_acc;
  logic [LEN_W-1:0]    r_beat_cnt, w_beat_cnt;
  logic [DATA_W-1:0]   r_data, w_data;
  logic                r_valid, w_valid;
  logic                r_active, w_active;
  logic                r_done, w_done;
  logic                r_invld, w_invld;
  logic [CNT_W-1:0]    r_pkt_cnt, w_pkt_cnt;

  function automatic logic [DATA_W-1:0] f_lfsr_step(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] sh;
    sh = v >> 1;
    if (v[0]) begin
      f_lfsr_step = sh ^ LFSR_POLY;
    end else begin
      f_lfsr_step = sh;
    end
  endfunction

  // Even parity accumulator, inverted when an error is being injected
  function automatic logic [DATA_W-1:0] f_parity_beat(input logic [DATA_W-1:0] acc,
                                                       input logic inj);
    if (inj) begin
      f_parity_beat = ~acc;
    end else begin
      f_parity_beat = acc;
    end
  endfunction

  // State and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_addr     <= '0;
      r_err      <= 1'b0;
      r_lfsr     <= LFSR_SEED;
      r_acc      <= '0;
      r_beat_cnt <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
      r_invld    <= 1'b0;
      r_pkt_cnt  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_len      <= w_len;
      r_addr     <= w_addr;
      r_err      <= w_err;
      r_lfsr     <= w_lfsr;
      r_acc      <= w_acc;
      r_beat_cnt <= w_beat_cnt;
      r_data     <= w_data;
      r_valid    <= w_valid;
      r_active   <= w_active;
      r_done     <= w_done;
      r_invld    <= w_invld;
      r_pkt_cnt  <= w_pkt_cnt;
    end
  end

  // Next state and next registered outputs; everything holds unless a beat is accepted
  always_comb begin
    w_state_nx = r_state;
    w_len      = r_len;
    w_addr     = r_addr;
    w_err      = r_err;
    w_lfsr     = r_lfsr;
    w_acc      = r_acc;
    w_beat_cnt = r_beat_cnt;
    w_data     = r_data;
    w_valid    = r_valid;
    w_active   = r_active;
    w_done     = 1'b0;
    w_invld    = r_invld;
    w_pkt_cnt  = r_pkt_cnt;
    case (r_state)
      S_IDLE: begin
        w_data   = '0;
        w_valid  = 1'b0;
        w_active = 1'b0;
        w_invld  = 1'b0;
        if (start) begin
          w_state_nx = S_HEADER;
          w_len      = cfg_len;
          w_addr     = cfg_addr;
          w_err      = cfg_err_inj;
          w_data     = {cfg_len, cfg_addr};
          w_acc      = {cfg_len, cfg_addr};
          w_beat_cnt = '0;
          w_valid    = 1'b1;
          w_active   = 1'b1;
          w_invld    = ({1'b0, cfg_addr} >= DEST_LIM);
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_HEADER: begin
        if (!busy) begin
          if (r_len != '0) begin
            w_state_nx = S_PAYLOAD;
            w_data     = r_lfsr;
            w_valid    = 1'b1;
          end else begin
            w_state_nx = S_PARITY;
            w_data     = f_parity_beat(r_acc, r_err);
            w_valid    = 1'b0;
          end
        end else begin
          w_state_nx = S_HEADER;
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          w_acc      = r_acc ^ r_data;
          w_lfsr     = f_lfsr_step(r_lfsr);
          w_beat_cnt = r_beat_cnt + LEN_W'(1);
          if (w_beat_cnt == r_len) begin
            w_state_nx = S_PARITY;
            w_data     = f_parity_beat(w_acc, r_err);
            w_valid    = 1'b0;
          end else begin
            w_data     = w_lfsr;
          end
        end else begin
          w_state_nx = S_PAYLOAD;
        end
      end
      S_PARITY: begin
        if (!busy) begin
          w_state_nx = S_IDLE;
          w_data     = '0;
          w_valid    = 1'b0;
          w_active   = 1'b0;
          w_invld    = 1'b0;
          w_done     = 1'b1;
          w_pkt_cnt  = r_pkt_cnt + CNT_W'(1);
        end else begin
          w_state_nx = S_PARITY;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_data     = '0;
        w_valid    = 1'b0;
        w_active   = 1'b0;
        w_invld    = 1'b0;
      end
    endcase
  end

  assign pkt_valid  = r_valid;
  assign data_in    = r_data;
  assign gen_active = r_active;
  assign done       = r_done;
  assign addr_invld = r_invld;
  assign pkt_cnt    = r_pkt_cnt;

endmodule

// File: tb/tb_router_pkt_gen.sv
// Directed bench for router_pkt_gen: every beat is compared each cycle against
// expected packets built from the header/LFSR/parity rules, plus hand-computed beats.
module tb_router_pkt_gen;

  localparam int NUM_DEST = 3;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [1:0]  cfg_addr;
  logic [5:0]  cfg_len;
  logic        cfg_err_inj;
  logic        busy;
  logic        pkt_valid;
  logic [7:0]  data_in;
  logic        gen_active;
  logic        done;
  logic        addr_invld;
  logic [15:0] pkt_cnt;

  int          n_chk;
  int          n_err;
  int          exp_cnt;
  logic [7:0]  m_lfsr;
  logic [7:0]  obs [0:65];

  router_pkt_gen dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .cfg_addr    (cfg_addr),
    .cfg_len     (cfg_len),
    .cfg_err_inj (cfg_err_inj),
    .busy        (busy),
    .pkt_valid   (pkt_valid),
    .data_in     (data_in),
    .gen_active  (gen_active),
    .done        (done),
    .addr_invld  (addr_invld),
    .pkt_cnt     (pkt_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  // Called at a negedge; returns at the negedge where done is high.
  task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic e,
                          input int busy_idx, input int busy_n, input bit ign_start);
    logic [7:0] exp_b [0:65];
    logic [7:0] acc;
    int nb;
    int idx;
    int bcnt;
    nb = int'(l) + 2;
    exp_b[0] = {l, a};
    acc = exp_b[0];
    for (int k = 1; k <= int'(l); k++) begin
      exp_b[k] = m_lfsr;
      acc      = acc ^ m_lfsr;
      m_lfsr   = lfsr_step(m_lfsr);
    end
    exp_b[nb-1] = e ? ~acc : acc;
    cfg_addr = a; cfg_len = l; cfg_err_inj = e; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    cfg_addr = ~a; cfg_len = ~l; cfg_err_inj = ~e;
    idx = 0;
    bcnt = 0;
    while (idx < nb) begin
      @(negedge clock);
      chk("beat", 32'(data_in), 32'(exp_b[idx]));
      chk("pkt_valid", 32'(pkt_valid), 32'(idx < nb - 1));
      chk("gen_active", 32'(gen_active), 32'd1);
      chk("addr_invld", 32'(addr_invld), 32'(int'(a) >= NUM_DEST));
      chk("done_low", 32'(done), 32'd0);
      if (idx == busy_idx && bcnt < busy_n) begin
        busy = 1'b1;
        bcnt++;
      end else begin
        busy = 1'b0;
        obs[idx] = data_in;
        idx++;
      end
      start = (ign_start && idx == 2) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    exp_cnt++;
    @(negedge clock);
    chk("done_pulse", 32'(done), 32'd1);
    chk("idle_active", 32'(gen_active), 32'd0);
    chk("idle_valid", 32'(pkt_valid), 32'd0);
    chk("idle_data", 32'(data_in), 32'd0);
    chk("pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
    if (ign_start) begin
      @(negedge clock);
      chk("start_ignored", 32'(gen_active), 32'd0);
      chk("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pv"}, 32'(pkt_valid), 32'd0);
    chk({tag, "_data"}, 32'(data_in), 32'd0);
    chk({tag, "_active"}, 32'(gen_active), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_invld"}, 32'(addr_invld), 32'd0);
    chk({tag, "_cnt"}, 32'(pkt_cnt), 32'd0);
  endtask

  initial begin
    n_chk = 0; n_err = 0; exp_cnt = 0; m_lfsr = 8'hA5;
    resetn = 1'b0; start = 1'b0; busy = 1'b0;
    cfg_addr = 2'd0; cfg_len = 6'd0; cfg_err_inj = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clock);

    // Test 1: single-beat packet with hand-computed beats
    send_pkt(2'd0, 6'd1, 1'b0, -1, 0, 1'b0);
    chk("t1_hdr", 32'(obs[0]), 32'h04);
    chk("t1_pay", 32'(obs[1]), 32'hA5);
    chk("t1_par", 32'(obs[2]), 32'hA1);

    // Test 2: len=14 to address 1, back-to-back after test 1
    send_pkt(2'd1, 6'd14, 1'b0, -1, 0, 1'b0);
    chk("t2_hdr", 32'(obs[0]), 32'h39);
    chk("t2_pay1", 32'(obs[1]), 32'hEA);

    // Test 3: busy held 5 cycles on the 4th payload beat; stray start mid-packet
    send_pkt(2'd2, 6'd6, 1'b0, 4, 5, 1'b1);

    // Test 4: zero-length with error injection, busy on the parity beat
    send_pkt(2'd2, 6'd0, 1'b1, 1, 2, 1'b0);
    chk("t4_hdr", 32'(obs[0]), 32'h02);
    chk("t4_par", 32'(obs[1]), 32'hFD);

    // Test 5: invalid address still sent, flagged and counted
    send_pkt(2'd3, 6'd4, 1'b0, 0, 1, 1'b0);

    // Maximum length packet
    send_pkt(2'd1, 6'd63, 1'b0, -1, 0, 1'b0);

    // Test 6: reset mid-payload, then replay test 1
    cfg_addr = 2'd3; cfg_len = 6'd10; cfg_err_inj = 1'b0; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("t6_mid_active", 32'(gen_active), 32'd1);
    resetn = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge clock);
    resetn = 1'b1;
    m_lfsr = 8'hA5;
    exp_cnt = 0;
    @(negedge clock);
    chk("t6_stay_idle", 32'(gen_active), 32'd0);
    send_pkt(2'd0, 6'd1, 1'b0, -1, 0, 1'b0);
    chk("t6_hdr", 32'(obs[0]), 32'h04);
    chk("t6_pay", 32'(obs[1]), 32'hA5);
    chk("t6_par", 32'(obs[2]), 32'hA1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
